uart_link: RTL and testbench
============================

Name: uart_link

Overview:
- Self-contained 8-bit UART block: programmable baud-tick generator, transmitter and receiver, all on one clock.
- Transmitter serialises `tx_data` with even parity onto `tx_out`. Receiver deserialises `rx_in`, checks parity and stop bit, and presents the byte.
- Benches loop `tx_out` back to `rx_in`. Direct drive of `rx_in` is used for error injection.

Parameters:
- DIV0, default 326: baud-tick divisor for `sel`=00 (≈9600 baud×16 at 50 MHz).
- DIV1, default 163: divisor for `sel`=01.
- DIV2, default 27: divisor for `sel`=10 (≈115200×16).
- DIV3, default 1: divisor for `sel`=11 (tick every clock; simulation speed).
- OVS, default 16: oversampling ticks per bit.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- sel  in  2  baud select: 00→DIV0, 01→DIV1, 10→DIV2, 11→DIV3.
- start_bit  in  1  transmit request, level-sensitive.
- stop_bit  in  1  value driven in the stop-bit slot (normally 1; 0 forces a framing error).
- tx_data  in  8  byte to transmit.
- tx_out  out  1  serial line out, idle high.
- tx_busy  out  1  high while a frame is in progress.
- rx_in  in  1  serial line in.
- data_out  out  8  last received byte.
- rx_valid  out  1  one-clock pulse at end of every received frame.
- parity_error  out  1  even-parity mismatch in the last frame.
- stopbit_error  out  1  stop bit sampled 0 in the last frame.

Behaviour:
- Reset (async, immediate):
  - `tx_out`=1; `tx_busy`=0; `data_out`=0; `rx_valid`=0; `parity_error`=0; `stopbit_error`=0.
  - All counters and FSMs go to IDLE, including mid-frame.
- Baud generator:
  - Down-counter reloads with DIV(`sel`)−1 and emits a one-clock `tick` enable at zero; DIV=1 gives tick every clock.
  - A `sel` change takes effect at the next reload.
  - Baud timing is a clock enable only; no derived clocks.
- Frame (11 bits): start 0, data bits 0..7 LSB first, even parity (XOR of data), stop = `stop_bit`. Each bit lasts OVS ticks.
- TX FSM IDLE→START→DATA(×8)→PARITY→STOP→IDLE:
  - In IDLE, on a tick with `start_bit`=1, latch `tx_data` and `stop_bit` and enter START.
  - Later changes to `tx_data`/`stop_bit` do not affect the current frame.
  - `tx_busy`=1 from START to end of STOP.
  - `start_bit` still high at STOP end starts the next frame immediately: no idle gap, fresh `tx_data`.
  - `start_bit` low at STOP end returns the FSM to IDLE with `tx_out`=1.
- RX input synchronisation: `rx_in` passes through a 2-flop synchroniser.
- RX FSM IDLE→START→DATA(×8)→PARITY→STOP→IDLE:
  - In IDLE, a synchronised 0 starts the OVS tick count.
  - At tick OVS/2 the start bit is re-checked. If it is 1, the event is a glitch: return to IDLE with no flags and no `rx_valid`.
  - Each later bit is sampled at mid-bit (every OVS ticks after the start-bit centre). Data bits shift in LSB first.
- RX stop-bit handling, at the stop-bit sample:
  - `data_out` takes the byte.
  - `parity_error` = (XOR of data) ≠ parity bit.
  - `stopbit_error` = stop sample == 0.
  - `rx_valid` pulses for one clock.
  - RX returns to IDLE. Flags hold until the next frame completes.
- If a frame has a bad stop bit and the line stays low, the receiver re-arms only after the line returns high (break condition).
- Latency:
  - `sel`=11: TX frame = 176 clocks.
  - Loopback `rx_valid` ≈ 2 (sync) + 168 clocks after the start-bit falling edge on `tx_out`.

Test Plan:
- Reset: assert `rst` mid-frame → `tx_out`=1, `tx_busy`=0, `data_out`=0x00, both error flags 0 in the same cycle.
- Loopback, `sel`=11, `tx_data`=0x69, `stop_bit`=1, `start_bit` pulsed:
  - `tx_out` bits: 0,1,0,0,1,0,1,1,0,0(parity),1, each 16 clocks.
  - Receiver: `data_out`=0x69, `parity_error`=0, `stopbit_error`=0, `rx_valid` one pulse.
- Loopback with `stop_bit`=0, byte 0xA5 → `data_out`=0xA5, `stopbit_error`=1, `parity_error`=0.
- Direct `rx_in` drive with 0x01 and parity bit 0 → `parity_error`=1, `data_out`=0x01.
- Back-to-back: `start_bit` held high, `tx_data` changed 0x11→0x22 mid-frame:
  - Receiver sees 0x11 then 0x22.
  - Exactly 176 clocks between the two `rx_valid` pulses.
- Glitch and baud select:
  - A 3-clock low pulse on `rx_in` → no `rx_valid`, flags unchanged.
  - `sel`=10 → bit period = 27×16 clocks.

Source files
------------

// File: rtl/uart_link.sv
// Self-contained 8-bit UART: programmable baud-tick generator, even-parity transmitter
// and oversampling receiver, all in the clk domain with tick used as a clock enable.
module uart_link #(
   parameter int DIV0 = 326,
   parameter int DIV1 = 163,
   parameter int DIV2 = 27,
   parameter int DIV3 = 1,
   parameter int OVS  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] sel,
   input  logic       start_bit,
   input  logic       stop_bit,
   input  logic [7:0] tx_data,
   output logic       tx_out,
   output logic       tx_busy,
   input  logic       rx_in,
   output logic [7:0] data_out,
   output logic       rx_valid,
   output logic       parity_error,
   output logic       stopbit_error
);

   localparam int CW = (OVS > 2) ? $clog2(OVS) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(OVS / 2 - 1);

   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

   function automatic logic [15:0] reload_val(input logic [1:0] s);
      case (s)
         2'b00:   reload_val = 16'(DIV0 - 1);
         2'b01:   reload_val = 16'(DIV1 - 1);
         2'b10:   reload_val = 16'(DIV2 - 1);
         default: reload_val = 16'(DIV3 - 1);
      endcase
   endfunction

   logic [15:0] baud_cnt_q, baud_cnt_d;
   logic        tick;

   tx_state_t   tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        tx_stop_q, tx_stop_d;

   logic        rx_s1_q, rx_s2_q;
   rx_state_t   rx_state_q, rx_state_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_shift_q, rx_shift_d;
   logic        rx_par_q, rx_par_d;
   logic [7:0]  data_out_q, data_out_d;
   logic        rx_valid_q, rx_valid_d;
   logic        perr_q, perr_d;
   logic        serr_q, serr_d;

   // Baud generator: the reload picks up sel, so a change lands at the next zero.
   assign tick = (baud_cnt_q == '0);

   always_comb begin
      if (tick) baud_cnt_d = reload_val(sel);
      else      baud_cnt_d = baud_cnt_q - 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) baud_cnt_q <= '0;
      else     baud_cnt_q <= baud_cnt_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_byte_q  <= '0;
         tx_stop_q  <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_byte_q  <= tx_byte_d;
         tx_stop_q  <= tx_stop_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_byte_d  = tx_byte_q;
      tx_stop_d  = tx_stop_q;
      if (tick) begin
         case (tx_state_q)
            TX_IDLE: begin
               if (start_bit) begin
                  tx_byte_d  = tx_data;
                  tx_stop_d  = stop_bit;
                  tx_cnt_d   = '0;
                  tx_state_d = TX_START;
               end
            end
            default: begin
               if (tx_cnt_q == CNT_LAST) begin
                  tx_cnt_d = '0;
                  case (tx_state_q)
                     TX_START: begin
                        tx_bit_d   = '0;
                        tx_state_d = TX_DATA;
                     end
                     TX_DATA: begin
                        if (tx_bit_q == 3'd7) tx_state_d = TX_PARITY;
                        else                  tx_bit_d   = tx_bit_q + 3'd1;
                     end
                     TX_PARITY: tx_state_d = TX_STOP;
                     TX_STOP: begin
                        // Held request chains the next frame with no idle gap.
                        if (start_bit) begin
                           tx_byte_d  = tx_data;
                           tx_stop_d  = stop_bit;
                           tx_state_d = TX_START;
                        end else begin
                           tx_state_d = TX_IDLE;
                        end
                     end
                     default: tx_state_d = TX_IDLE;
                  endcase
               end else begin
                  tx_cnt_d = tx_cnt_q + 1'b1;
               end
            end
         endcase
      end
   end

   always_comb begin
      tx_out  = 1'b1;
      tx_busy = (tx_state_q != TX_IDLE);
      case (tx_state_q)
         TX_START:  tx_out = 1'b0;
         TX_DATA:   tx_out = tx_byte_q[tx_bit_q];
         TX_PARITY: tx_out = ^tx_byte_q;
         TX_STOP:   tx_out = tx_stop_q;
         default:   tx_out = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_par_q   <= 1'b0;
         data_out_q <= '0;
         rx_valid_q <= 1'b0;
         perr_q     <= 1'b0;
         serr_q     <= 1'b0;
      end else begin
         rx_s1_q    <= rx_in;
         rx_s2_q    <= rx_s1_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_par_q   <= rx_par_d;
         data_out_q <= data_out_d;
         rx_valid_q <= rx_valid_d;
         perr_q     <= perr_d;
         serr_q     <= serr_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_par_d   = rx_par_q;
      data_out_d = data_out_q;
      rx_valid_d = 1'b0;
      perr_d     = perr_q;
      serr_d     = serr_q;
      case (rx_state_q)
         RX_IDLE: begin
            if (!rx_s2_q) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_START;
            end
         end
         RX_START: begin
            if (tick) begin
               if (rx_cnt_q == CNT_MID) begin
                  rx_cnt_d   = '0;
                  rx_bit_d   = '0;
                  rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cnt_d = rx_cnt_q + 1'b1;
               end
            end
         end
         RX_DATA, RX_PARITY, RX_STOP: begin
            if (tick) begin
               if (rx_cnt_q == CNT_LAST) begin
                  rx_cnt_d = '0;
                  case (rx_state_q)
                     RX_DATA: begin
                        rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                        if (rx_bit_q == 3'd7) rx_state_d = RX_PARITY;
                        else                  rx_bit_d   = rx_bit_q + 3'd1;
                     end
                     RX_PARITY: begin
                        rx_par_d   = rx_s2_q;
                        rx_state_d = RX_STOP;
                     end
                     default: begin
                        data_out_d = rx_shift_q;
                        perr_d     = (^rx_shift_q) != rx_par_q;
                        serr_d     = !rx_s2_q;
                        rx_valid_d = 1'b1;
                        // A low stop bit may be a break; wait for the line to recover.
                        rx_state_d = rx_s2_q ? RX_IDLE : RX_BREAK;
                     end
                  endcase
               end else begin
                  rx_cnt_d = rx_cnt_q + 1'b1;
               end
            end
         end
         RX_BREAK: begin
            if (rx_s2_q) rx_state_d = RX_IDLE;
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   assign data_out      = data_out_q;
   assign rx_valid      = rx_valid_q;
   assign parity_error  = perr_q;
   assign stopbit_error = serr_q;

endmodule

// File: tb/tb_uart_link.sv
// Scoreboard bench for uart_link: stimulus pushes expected received frames, a monitor
// pops and compares them whenever rx_valid pulses.
module tb_uart_link;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] sel = 2'b11;
   logic       start_bit = 1'b0;
   logic       stop_bit = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_out, tx_busy, rx_in, rx_valid, parity_error, stopbit_error;
   logic [7:0] data_out;
   logic       loop = 1'b1;
   logic       rx_drv = 1'b1;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       se;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          valid_cyc[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          valid_cnt = 0;
   int          saved_cnt;
   int          n;
   logic [10:0] frame;

   assign rx_in = loop ? tx_out : rx_drv;

   uart_link dut (
      .clk(clk), .rst(rst), .sel(sel), .start_bit(start_bit), .stop_bit(stop_bit),
      .tx_data(tx_data), .tx_out(tx_out), .tx_busy(tx_busy), .rx_in(rx_in),
      .data_out(data_out), .rx_valid(rx_valid), .parity_error(parity_error),
      .stopbit_error(stopbit_error)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic pe, input logic se);
      exp_t e;
      e.d  = d;
      e.pe = pe;
      e.se = se;
      sb.push_back(e);
   endtask

   task automatic wait_busy();
      int i = 0;
      while (!tx_busy && i < 1000) begin
         @(negedge clk);
         i++;
      end
      chk("tx_busy_rise", {31'd0, tx_busy}, 32'd1);
   endtask

   task automatic wait_drain(input int bound);
      int i = 0;
      while (sb.size() != 0 && i < bound) begin
         @(negedge clk);
         i++;
      end
      chk("scoreboard_drained", sb.size(), 32'd0);
   endtask

   task automatic send_raw(input logic [7:0] d, input logic par, input logic stp);
      logic [10:0] f;
      f = {stp, par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
         rx_drv = f[i];
         repeat (16) @(negedge clk);
      end
      rx_drv = 1'b1;
   endtask

   // Monitor: every rx_valid pulse must match the oldest expected frame.
   initial forever begin
      @(negedge clk);
      if (!rst && rx_valid) begin
         valid_cnt++;
         valid_cyc.push_back(cyc);
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rx_valid: got data_out %0h expected no frame", data_out);
         end else begin
            mon_e = sb.pop_front();
            chk("rx_data_out", {24'd0, data_out}, {24'd0, mon_e.d});
            chk("rx_parity_error", {31'd0, parity_error}, {31'd0, mon_e.pe});
            chk("rx_stopbit_error", {31'd0, stopbit_error}, {31'd0, mon_e.se});
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_tx_out", {31'd0, tx_out}, 32'd1);
      chk("reset_tx_busy", {31'd0, tx_busy}, 32'd0);
      chk("reset_data_out", {24'd0, data_out}, 32'd0);
      chk("reset_parity_error", {31'd0, parity_error}, 32'd0);
      chk("reset_stopbit_error", {31'd0, stopbit_error}, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // Loopback 0x69 with the serial waveform checked at every bit centre.
      tx_data = 8'h69;
      stop_bit = 1'b1;
      frame = {1'b1, 1'b0, 8'h69, 1'b0};
      push_exp(8'h69, 1'b0, 1'b0);
      start_bit = 1'b1;
      wait_busy();
      start_bit = 1'b0;
      repeat (7) @(negedge clk);
      for (int i = 0; i < 11; i++) begin
         chk($sformatf("tx_bit%0d", i), {31'd0, tx_out}, {31'd0, frame[i]});
         repeat (16) @(negedge clk);
      end
      wait_drain(400);

      // Forced framing error.
      tx_data = 8'hA5;
      stop_bit = 1'b0;
      push_exp(8'hA5, 1'b0, 1'b1);
      start_bit = 1'b1;
      wait_busy();
      start_bit = 1'b0;
      stop_bit = 1'b1;
      wait_drain(400);
      repeat (20) @(negedge clk);

      // Direct drive with wrong parity.
      loop = 1'b0;
      rx_drv = 1'b1;
      repeat (10) @(negedge clk);
      push_exp(8'h01, 1'b1, 1'b0);
      send_raw(8'h01, 1'b0, 1'b1);
      wait_drain(400);
      repeat (20) @(negedge clk);

      // Glitch must be rejected and leave the flags alone.
      saved_cnt = valid_cnt;
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      repeat (60) @(negedge clk);
      chk("glitch_no_rx_valid", valid_cnt, saved_cnt);
      chk("glitch_data_out", {24'd0, data_out}, 32'h01);
      chk("glitch_parity_error", {31'd0, parity_error}, 32'd1);
      chk("glitch_stopbit_error", {31'd0, stopbit_error}, 32'd0);

      // Asynchronous reset in the middle of a frame.
      loop = 1'b1;
      tx_data = 8'h3C;
      start_bit = 1'b1;
      wait_busy();
      start_bit = 1'b0;
      repeat (40) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midreset_tx_out", {31'd0, tx_out}, 32'd1);
      chk("midreset_tx_busy", {31'd0, tx_busy}, 32'd0);
      chk("midreset_data_out", {24'd0, data_out}, 32'd0);
      chk("midreset_parity_error", {31'd0, parity_error}, 32'd0);
      chk("midreset_stopbit_error", {31'd0, stopbit_error}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      // Back-to-back frames with tx_data changed mid-frame.
      tx_data = 8'h11;
      push_exp(8'h11, 1'b0, 1'b0);
      push_exp(8'h22, 1'b0, 1'b0);
      start_bit = 1'b1;
      wait_busy();
      repeat (100) @(negedge clk);
      tx_data = 8'h22;
      repeat (100) @(negedge clk);
      start_bit = 1'b0;
      wait_drain(600);
      if (valid_cyc.size() >= 2)
         n = valid_cyc[valid_cyc.size()-1] - valid_cyc[valid_cyc.size()-2];
      else
         n = 0;
      chk("b2b_rx_valid_spacing", n, 32'd176);
      repeat (20) @(negedge clk);

      // Slower baud select: start bit of 0xFF lasts exactly one bit period.
      sel = 2'b10;
      tx_data = 8'hFF;
      push_exp(8'hFF, 1'b0, 1'b0);
      start_bit = 1'b1;
      n = 0;
      while (tx_out && n < 200) begin
         @(negedge clk);
         n++;
      end
      start_bit = 1'b0;
      n = 0;
      while (!tx_out && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("sel10_bit_period", n, 32'd432);
      wait_drain(6000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
